// File: rtl/rr_arb2x1_if.sv
// Handshake bundle for the 2:1 round-robin packet arbiter: two source streams,
// the arbitrated output stream and the downstream mux select.
interface rr_arb2x1_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_ready;
    logic             s;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             o_src;
    logic             o_ready;

    // Master drives the sources and downstream ready; slave is the arbiter.
    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, o_ready,
        input  a_ready, b_ready, s, o_valid, o_data, o_last, o_src
    );

    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, o_ready,
        output a_ready, b_ready, s, o_valid, o_data, o_last, o_src
    );
endinterface

// File: rtl/rr_arb2x1.sv
// Two-input round-robin packet arbiter with a registered output stage.
// A winning source holds the grant until its last beat has been transferred.
module rr_arb2x1 #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arb2x1_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCK_A = 2'd1;
    localparam logic [1:0] LOCK_B = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_last_q, o_last_d;
    logic             o_src_q, o_src_d;

    logic             grant;
    logic             load;
    logic             a_rdy;
    logic             b_rdy;
    logic             xfer;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;

    // ptr names the previous winner, so on a tie the other source is granted.
    always_comb begin
        grant = ptr_q;
        case (state_q)
            LOCK_A: grant = 1'b0;
            LOCK_B: grant = 1'b1;
            default: begin
                if (bus.a_valid && bus.b_valid) begin
                    grant = ~ptr_q;
                end else if (bus.a_valid) begin
                    grant = 1'b0;
                end else if (bus.b_valid) begin
                    grant = 1'b1;
                end else begin
                    grant = ptr_q;
                end
            end
        endcase
    end

    assign load      = !o_valid_q || bus.o_ready;
    assign a_rdy     = load && !grant && bus.a_valid;
    assign b_rdy     = load &&  grant && bus.b_valid;
    assign xfer      = a_rdy || b_rdy;
    assign beat_data = grant ? bus.b_data : bus.a_data;
    assign beat_last = grant ? bus.b_last : bus.a_last;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        o_src_d   = o_src_q;

        if (xfer) begin
            ptr_d = grant;
            if (beat_last) begin
                state_d = IDLE;
            end else begin
                state_d = grant ? LOCK_B : LOCK_A;
            end
        end

        // A non-granted load cycle empties the output register.
        if (load) begin
            o_valid_d = xfer;
            if (xfer) begin
                o_data_d = beat_data;
                o_last_d = beat_last;
                o_src_d  = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b1;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_src_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_src_q   <= o_src_d;
        end
    end

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign bus.s       = grant;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_last  = o_last_q;
    assign bus.o_src   = o_src_q;

endmodule

// File: tb/tb_rr_arb2x1.sv
// Bench for rr_arb2x1: directed packet scenarios followed by random traffic,
// all checked against a packet-level arbitration model.
module tb_rr_arb2x1;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arb2x1_if #(.WIDTH(WIDTH)) bus ();

    rr_arb2x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: current packet owner (-1 when none), previous winner, and the output beat.
    int               owner;
    int               lastWinner;
    logic             mValid;
    logic [WIDTH-1:0] mData;
    logic             mLast;
    logic             mSrc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        owner      = -1;
        lastWinner = 1;
        mValid     = 1'b0;
        mData      = '0;
        mLast      = 1'b0;
        mSrc       = 1'b0;
    endtask

    // Drive one cycle, check the combinational outputs before the edge and the registered ones after.
    task automatic applyStimulus(input logic rst, input logic av, input logic [WIDTH-1:0] ad, input logic al,
                                 input logic bv, input logic [WIDTH-1:0] bd, input logic bl, input logic ordy);
        int   g;
        logic canLoad, expA, expB, moved;
        rst_n       = rst;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.a_last  = al;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.b_last  = bl;
        bus.o_ready = ordy;
        #2;
        if (owner >= 0)     g = owner;
        else if (av && bv)  g = 1 - lastWinner;
        else if (av)        g = 0;
        else if (bv)        g = 1;
        else                g = lastWinner;
        canLoad = !mValid || ordy;
        expA    = canLoad && (g == 0) && av;
        expB    = canLoad && (g == 1) && bv;
        checkOutput("s", 32'(bus.s), 32'(g));
        checkOutput("a_ready", 32'(bus.a_ready), 32'(expA));
        checkOutput("b_ready", 32'(bus.b_ready), 32'(expB));
        @(posedge clk);
        #1;
        if (!rst) begin
            modelReset();
        end else begin
            moved = expA || expB;
            if (moved) begin
                lastWinner = g;
                owner      = ((g == 1) ? bl : al) ? -1 : g;
            end
            if (canLoad) begin
                mValid = moved;
                if (moved) begin
                    mData = (g == 1) ? bd : ad;
                    mLast = (g == 1) ? bl : al;
                    mSrc  = (g == 1);
                end
            end
        end
        checkOutput("o_valid", 32'(bus.o_valid), 32'(mValid));
        if (mValid) begin
            checkOutput("o_data", 32'(bus.o_data), 32'(mData));
            checkOutput("o_last", 32'(bus.o_last), 32'(mLast));
            checkOutput("o_src", 32'(bus.o_src), 32'(mSrc));
        end
    endtask

    initial begin
        modelReset();
        rst_n       = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.a_last  = 1'b0;
        bus.b_valid = 1'b0;
        bus.b_data  = '0;
        bus.b_last  = 1'b0;
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rst_o_data", 32'(bus.o_data), 32'h0);
        checkOutput("rst_o_last", 32'(bus.o_last), 32'h0);
        checkOutput("rst_o_src", 32'(bus.o_src), 32'h0);
        checkOutput("rst_s_ptr", 32'(bus.s), 32'h1);

        $display("[TB] single-beat packets from A");
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_beat0", 32'(bus.o_data), 32'h11);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_beat1", 32'(bus.o_data), 32'h22);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_beat2", 32'(bus.o_data), 32'h33);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_drain", 32'(bus.o_valid), 32'h0);

        $display("[TB] alternation with both sources valid");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
        checkOutput("t2_a0", 32'(bus.o_data), 32'hA0);
        applyStimulus(1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
        checkOutput("t2_b0", 32'(bus.o_data), 32'hB0);
        applyStimulus(1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1);
        checkOutput("t2_a1", 32'(bus.o_data), 32'hA1);
        applyStimulus(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1);
        checkOutput("t2_b1", 32'(bus.o_data), 32'hB1);

        $display("[TB] four-beat packet from A with B waiting");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), (i == 3), 1'b1, 8'hB7, 1'b1, 1'b1);
            checkOutput("t3_src_a", 32'(bus.o_src), 32'h0);
            checkOutput("t3_last", 32'(bus.o_last), 32'(i == 3));
        end
        applyStimulus(1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 8'hB7, 1'b1, 1'b1);
        checkOutput("t3_b_after", 32'(bus.o_data), 32'hB7);

        $display("[TB] output stall");
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h5B, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b0);
            checkOutput("t4_hold", 32'(bus.o_data), 32'h5A);
        end
        applyStimulus(1'b1, 1'b1, 8'h5B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t4_resume", 32'(bus.o_data), 32'h5B);

        $display("[TB] lock held while A pauses");
        applyStimulus(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1);
            checkOutput("t5_bubble", 32'(bus.o_valid), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1);
        checkOutput("t5_a_done", 32'(bus.o_data), 32'hC1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1);
        checkOutput("t5_b_next", 32'(bus.o_src), 32'h1);

        $display("[TB] reset in the middle of a B packet");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 8'hE1, 1'b1, 1'b1);
        checkOutput("t6_flush", 32'(bus.o_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 8'hE1, 1'b1, 1'b1);
        checkOutput("t6_a_wins", 32'(bus.o_src), 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb2x1.md
Name: rr_arb2x1

Overview:
- Two-input round-robin packet arbiter with a registered output stage.
- Sits directly upstream of the 2:1 data mux: its select output drives the mux select.
  - s=0 passes input a.
  - s=1 passes input b.
- It also carries the arbitrated stream itself, with valid/ready handshakes on both sides.
- Once a source wins, it keeps the grant until its packet's last beat has been transferred.

Parameters:
- WIDTH, 8, data width of each input and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a_valid  input  1  source A beat valid
- a_data  input  WIDTH  source A beat data
- a_last  input  1  source A final beat of packet
- a_ready  output  1  source A beat accepted this cycle
- b_valid  input  1  source B beat valid
- b_data  input  WIDTH  source B beat data
- b_last  input  1  source B final beat of packet
- b_ready  output  1  source B beat accepted this cycle
- s  output  1  combinational current grant (0=A, 1=B), drives downstream mux select
- o_valid  output  1  output beat valid (registered)
- o_data  output  WIDTH  output beat data (registered)
- o_last  output  1  output final beat of packet (registered)
- o_src  output  1  source of held output beat (registered; 0=A, 1=B)
- o_ready  input  1  downstream accepts output beat

Behaviour:
- Single clock domain; all state updates on rising clk; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - o_valid=0, o_data=0, o_last=0, o_src=0.
  - State=IDLE; priority pointer ptr=1, so A wins the first tie.
  - Reset applied mid-packet discards the lock and the held beat.
- Load enable: load = !o_valid || o_ready. The output register accepts a new beat only when load=1.
  - With load=1 and a beat granted, the output register captures data/last/src on that edge.
  - With load=1 and no beat granted, o_valid goes to 0.
  - With load=0, the output register holds all values.
- Latency: accepted input beat appears on o_* exactly 1 cycle later. Full throughput of 1 beat/cycle while o_ready=1.
- State machine (IDLE, LOCK_A, LOCK_B):
  - IDLE, grant selection:
    - Only A valid -> A.
    - Only B valid -> B.
    - Both valid -> source != ptr.
    - Neither -> no grant. s holds the previous ptr value.
  - IDLE, on accepted beat from X:
    - ptr := X.
    - If last=0, go to LOCK_X.
    - If last=1, stay in IDLE.
  - LOCK_X: grant fixed to X regardless of the other source's valid.
    - If X_valid=0, no transfer: output bubble, state held.
    - On accepted beat from X with X_last=1 -> IDLE.
- Handshake:
  - a_ready = load && grant==A && a_valid.
  - b_ready = load && grant==B && b_valid.
  - Never both 1.
  - Ready depends combinationally on o_ready. A transfer occurs when valid && ready.
- s equals the current grant in the cycle it is driven. In IDLE with no valid it equals ptr.
- Output stalled (o_valid=1, o_ready=0): both readies 0; state, ptr and o_* frozen.
- Single-beat packets (last=1 on the first beat) never enter a LOCK state. Both sources continuously valid with last=1 alternate A,B,A,B.
- Input valid dropping mid-packet does not release the lock; only a transferred last beat does.

Test Plan:
- Reset then A sends 3 single-beat packets (0x11,0x22,0x33, last=1), B idle, o_ready=1 -> a_ready=1 each cycle; o_data=0x11,0x22,0x33 on cycles 1-3 after the first transfer; o_src=0; s=0.
- Both valid, all last=1, A data 0xA0.., B data 0xB0.., o_ready=1 -> o_data alternates 0xA0,0xB0,0xA1,0xB1; first grant to A; s toggles each cycle.
- A sends 4-beat packet (last on beat 4) while B continuously valid -> b_ready=0 for all four beats; B granted in the cycle after A's last transfer; o_last=1 only on A's fourth beat.
- o_ready=0 for 3 cycles with o_valid=1, o_data=0x5A -> o_data held at 0x5A; a_ready=b_ready=0; the next beat appears 1 cycle after o_ready returns to 1.
- LOCK_A, A valid dropped for 2 cycles while B valid -> o_valid=0 bubbles; B not granted; A resumes and completes the packet; B then granted.
- rst_n=0 for one edge mid-packet in LOCK_B -> next cycle o_valid=0, state IDLE; with both valid, A wins.
